// File: rtl/base64_stream_ctrl.sv
// Character-to-sextet stream packer for base64: 7-bit ASCII in, 6-bit indices out,
// with valid/ready flow control on both sides and optional zero-sextet group padding.
module base64_stream_ctrl #(
  parameter int LEN_W  = 8,
  parameter bit PAD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_ascii,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_sextet,
  output logic             out_pad,
  output logic             msg_done,
  output logic             busy,
  output logic [LEN_W-1:0] char_count,
  output logic             err_ovf
);

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, PAD, DONE} state_t;

  state_t      state, state_nxt;
  logic [11:0] bits_q, bits_sh, bits_nxt;
  logic [3:0]  nb, nb_sh, nb_nxt;
  logic [2:0]  grp_cnt, grp_inc;

  logic accept, emit, load_ok, chr, nul;
  logic ld_full, ld_part, ld_pad, load;

  assign accept  = in_valid & in_ready;
  assign emit    = out_valid & out_ready;
  assign load_ok = !out_valid | out_ready;
  assign chr     = accept & (in_ascii != 7'd0);
  assign nul     = accept & (in_ascii == 7'd0);

  assign ld_full = load_ok & (nb >= 4'd6);
  assign ld_part = load_ok & (state == FLUSH) & (nb != 4'd0) & (nb < 4'd6);
  assign ld_pad  = load_ok & (state == PAD);
  assign load    = ld_full | ld_part | ld_pad;
  assign grp_inc = (grp_cnt == 3'd6) ? 3'd0 : grp_cnt + 3'd1;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (chr) state_nxt = in_last ? FLUSH : RUN;
      RUN:     if (nul || (chr && in_last)) state_nxt = FLUSH;
      FLUSH:   if (nb == 4'd0 && load_ok)
                 state_nxt = (PAD_EN && grp_cnt != 3'd0) ? PAD : DONE;
      PAD:     if (ld_pad && grp_inc == 3'd0) state_nxt = DONE;
      DONE:    if (!out_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst so every output reads 0 while reset is held.
  always_comb begin
    in_ready = 1'b0;
    msg_done = 1'b0;
    busy     = 1'b0;
    if (!rst) begin
      in_ready = (state == IDLE || state == RUN) && (nb <= 4'd5);
      msg_done = (state == DONE) && !out_valid;
      busy     = (state != IDLE) || out_valid;
    end
  end

  // ---------------- bit buffer ----------------
  // Bits below the valid region are always zero, so a partial tail is just bits_q[11:6].
  always_comb begin
    bits_sh = bits_q;
    nb_sh   = nb;
    if (ld_full) begin
      bits_sh = {bits_q[5:0], 6'd0};
      nb_sh   = nb - 4'd6;
    end else if (ld_part) begin
      bits_sh = '0;
      nb_sh   = '0;
    end
    bits_nxt = bits_sh;
    nb_nxt   = nb_sh;
    if (chr) begin
      bits_nxt = bits_sh | ({in_ascii, 5'd0} >> nb_sh);
      nb_nxt   = nb_sh + 4'd7;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_q <= '0;
      nb     <= '0;
    end else begin
      bits_q <= bits_nxt;
      nb     <= nb_nxt;
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sextet <= '0;
      out_pad    <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_sextet <= ld_pad ? 6'd0 : bits_q[11:6];
      out_pad    <= ld_pad;
    end else if (emit) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               grp_cnt <= '0;
    else if (state == DONE && !out_valid)  grp_cnt <= '0;
    else if (load)                         grp_cnt <= grp_inc;
  end

  // ---------------- message statistics ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_count <= '0;
      err_ovf    <= 1'b0;
    end else if (chr) begin
      if (state == IDLE) begin
        char_count <= LEN_W'(1);
        err_ovf    <= 1'b0;
      end else if (&char_count) begin
        err_ovf    <= 1'b1;
      end else begin
        char_count <= char_count + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_base64_stream_ctrl.sv
// Bench for base64_stream_ctrl: two instances (padded/8-bit count, unpadded/2-bit count)
// checked every cycle against a message-level bit-string model, plus literal pins.
module tb_base64_stream_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv[2], ir[2], il[2], ov[2], ordy[2], opad[2], md[2], bsy[2], eo[2];
  logic [6:0] ia[2];
  logic [5:0] os[2];
  logic [7:0] cc0;
  logic [1:0] cc1;

  base64_stream_ctrl #(.LEN_W(8), .PAD_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_ascii(ia[0]),
    .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_sextet(os[0]),
    .out_pad(opad[0]), .msg_done(md[0]), .busy(bsy[0]), .char_count(cc0), .err_ovf(eo[0]));

  base64_stream_ctrl #(.LEN_W(2), .PAD_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_ascii(ia[1]),
    .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_sextet(os[1]),
    .out_pad(opad[1]), .msg_done(md[1]), .busy(bsy[1]), .char_count(cc1), .err_ovf(eo[1]));

  int n_chk = 0, n_fail = 0;
  int max_cnt[2] = '{255, 3};
  int pad_en[2]  = '{1, 0};

  // model: st 0 = idle, 1 = collecting, 2 = message closed and draining
  int   st[2], bw[2], er[2], nchar[2], ndone[2], ncap[2], ptr[2];
  bit   bits[2][0:1023];
  logic [5:0] cap[2][0:63];
  logic cap_pad[2][0:63];
  logic acc[2];
  logic prev_stall[2], prev_pad[2];
  logic [5:0] prev_os[2];

  logic [6:0] stim_c[0:1023];
  logic       stim_l[0:1023];
  int         slen;

  task automatic chk(string name, int d, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int data_sx(int d);
    return (bw[d] + 5) / 6;
  endfunction

  function automatic int total_sx(int d);
    int n;
    n = data_sx(d);
    if (pad_en[d] != 0 && n % 7 != 0) n += 7 - n % 7;
    return n;
  endfunction

  // sextet i of a message = message bits 6i..6i+5, zero beyond the end
  function automatic int exp_sx(int d, int i);
    int v;
    v = 0;
    for (int b = 0; b < 6; b++)
      v = (v << 1) | ((6*i + b < bw[d]) ? int'(bits[d][6*i + b]) : 0);
    return v;
  endfunction

  task automatic sample();
    for (int d = 0; d < 2; d++) begin
      int cc;
      bit ok;
      cc = (d == 0) ? int'(cc0) : int'(cc1);
      if (rst) begin
        st[d] = 0; bw[d] = 0; er[d] = 0; nchar[d] = 0;
        acc[d] = 1'b0; prev_stall[d] = 1'b0;
      end else begin
        chk("char_count", d, cc, (nchar[d] > max_cnt[d]) ? max_cnt[d] : nchar[d]);
        chk("err_ovf", d, int'(eo[d]), int'(nchar[d] > max_cnt[d]));
        if (st[d] == 0) begin
          chk("busy_idle", d, int'(bsy[d]), 0);
          chk("in_ready_idle", d, int'(ir[d]), 1);
        end
        if (st[d] == 2) chk("in_ready_flush", d, int'(ir[d]), 0);
        if (prev_stall[d]) begin
          chk("hold_valid", d, int'(ov[d]), 1);
          chk("hold_sextet", d, int'(os[d]), int'(prev_os[d]));
          chk("hold_pad", d, int'(opad[d]), int'(prev_pad[d]));
        end
        prev_stall[d] = ov[d] & ~ordy[d];
        prev_os[d]    = os[d];
        prev_pad[d]   = opad[d];

        if (ov[d] && ordy[d]) begin
          ok = (st[d] == 2) ? (er[d] < total_sx(d)) : (st[d] == 1 && 6*(er[d] + 1) <= bw[d]);
          chk("emit_allowed", d, int'(ok), 1);
          if (ok) begin
            chk("sextet", d, int'(os[d]), exp_sx(d, er[d]));
            chk("out_pad", d, int'(opad[d]), int'(st[d] == 2 && er[d] >= data_sx(d)));
            er[d]++;
          end
          if (ncap[d] < 64) begin
            cap[d][ncap[d]]     = os[d];
            cap_pad[d][ncap[d]] = opad[d];
            ncap[d]++;
          end
        end

        acc[d] = iv[d] & ir[d];
        if (acc[d]) begin
          if (ia[d] != 7'd0) begin
            if (st[d] == 0) begin st[d] = 1; bw[d] = 0; er[d] = 0; nchar[d] = 0; end
            for (int b = 6; b >= 0; b--) begin bits[d][bw[d]] = ia[d][b]; bw[d]++; end
            nchar[d]++;
            if (il[d]) st[d] = 2;
          end else if (st[d] == 1) begin
            st[d] = 2;
          end
        end

        if (md[d]) begin
          chk("done_state", d, int'(st[d] == 2 && er[d] == total_sx(d)), 1);
          ndone[d]++;
          st[d] = 0;
        end
      end
    end
  endtask

  task automatic drive(int rdy_pct, int vld_pct);
    for (int d = 0; d < 2; d++) begin
      if (acc[d]) begin ptr[d]++; acc[d] = 1'b0; iv[d] = 1'b0; end
      if (!iv[d] && ptr[d] < slen && $urandom_range(99) < vld_pct) begin
        iv[d] = 1'b1; ia[d] = stim_c[ptr[d]]; il[d] = stim_l[ptr[d]];
      end
      ordy[d] = ($urandom_range(99) < rdy_pct);
    end
  endtask

  task automatic cycle(int rdy_pct, int vld_pct);
    @(negedge clk); sample();
    @(posedge clk); #1; drive(rdy_pct, vld_pct);
  endtask

  task automatic run(int rdy_pct, int vld_pct);
    int n;
    n = 0;
    while (!(ptr[0] >= slen && ptr[1] >= slen && st[0] == 0 && st[1] == 0 && !iv[0] && !iv[1])
           && n < 20000) begin
      cycle(rdy_pct, vld_pct);
      n++;
    end
    chk("drain_timeout", 0, int'(n < 20000), 1);
  endtask

  task automatic new_phase();
    slen = 0; ptr[0] = 0; ptr[1] = 0; ncap[0] = 0; ncap[1] = 0;
  endtask

  task automatic add_char(logic [6:0] c, logic l);
    stim_c[slen] = c; stim_l[slen] = l; slen++;
  endtask

  task automatic add_str6(logic [41:0] s, logic last_on_end);
    for (int i = 0; i < 6; i++) add_char(s[41 - 7*i -: 7], last_on_end && i == 5);
  endtask

  task automatic chk_cap(int d, int n, logic [41:0] seq, logic [6:0] pads);
    chk("cap_len", d, ncap[d], n);
    for (int i = 0; i < n && i < ncap[d]; i++) begin
      chk("cap_sextet", d, int'(cap[d][i]), int'(seq[41 - 6*i -: 6]));
      chk("cap_pad", d, int'(cap_pad[d][i]), int'(pads[6 - i]));
    end
  endtask

  task automatic chk_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", d, int'(ir[d]), 0);
      chk("rst_out_valid", d, int'(ov[d]), 0);
      chk("rst_sextet", d, int'(os[d]), 0);
      chk("rst_pad", d, int'(opad[d]), 0);
      chk("rst_done", d, int'(md[d]), 0);
      chk("rst_busy", d, int'(bsy[d]), 0);
      chk("rst_err", d, int'(eo[d]), 0);
    end
    chk("rst_count", 0, int'(cc0), 0);
    chk("rst_count", 1, int'(cc1), 0);
  endtask

  task automatic gen_random(int nm);
    int len;
    logic [6:0] c;
    for (int m = 0; m < nm; m++) begin
      if ($urandom_range(5) == 0) add_char(7'd0, 1'($urandom_range(1)));
      len = $urandom_range(14, 1);
      for (int i = 0; i < len; i++) begin
        c = 7'($urandom_range(127, 1));
        if (i < len - 1) add_char(c, 1'b0);
        else if ($urandom_range(3) == 0) begin
          add_char(c, 1'b0);
          add_char(7'd0, 1'($urandom_range(1)));
        end else add_char(c, 1'b1);
      end
    end
  endtask

  localparam logic [41:0] ABCDEF = {7'h41, 7'h42, 7'h43, 7'h44, 7'h45, 7'h46};
  localparam logic [41:0] SX1    = {6'h20, 6'h30, 6'h28, 6'h1C, 6'h12, 6'h0B, 6'h06};
  localparam logic [41:0] SX_A   = {6'h20, 6'h20, 30'd0};
  localparam logic [41:0] SX_AB  = {6'h20, 6'h30, 6'h20, 24'd0};

  initial begin
    int nd;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ia[d] = '0; il[d] = 1'b0; ordy[d] = 1'b0; acc[d] = 1'b0;
      st[d] = 0; bw[d] = 0; er[d] = 0; nchar[d] = 0; ndone[d] = 0; ncap[d] = 0; ptr[d] = 0;
      prev_stall[d] = 1'b0; prev_pad[d] = 1'b0; prev_os[d] = '0;
    end
    slen = 0;
    #2 chk_reset_outputs();
    repeat (2) cycle(100, 0);
    rst = 1'b0;

    // "ABCDEF": exactly one full group, no padding; 2-bit counter saturates
    new_phase(); add_str6(ABCDEF, 1'b1); run(100, 100);
    chk_cap(0, 7, SX1, 7'b0); chk_cap(1, 7, SX1, 7'b0);
    chk("done_count", 0, ndone[0], 1); chk("done_count", 1, ndone[1], 1);
    chk("count6", 0, int'(cc0), 6); chk("count6", 1, int'(cc1), 3);
    chk("ovf6", 0, int'(eo[0]), 0); chk("ovf6", 1, int'(eo[1]), 1);

    // "A": two data sextets, five pad sextets on the padded instance
    new_phase(); add_char(7'h41, 1'b1); run(100, 100);
    chk_cap(0, 7, SX_A, 7'b0011111); chk_cap(1, 2, SX_A, 7'b0);
    chk("count1", 1, int'(cc1), 1); chk("ovf_clear", 1, int'(eo[1]), 0);

    // 'A','B', NUL terminator
    new_phase(); add_char(7'h41, 1'b0); add_char(7'h42, 1'b0); add_char(7'd0, 1'b0); run(100, 100);
    chk_cap(0, 7, SX_AB, 7'b0001111); chk_cap(1, 3, SX_AB, 7'b0);
    chk("count2", 0, int'(cc0), 2);

    // "HELLO" on the 2-bit counter
    new_phase();
    add_char(7'h48, 1'b0); add_char(7'h45, 1'b0); add_char(7'h4C, 1'b0);
    add_char(7'h4C, 1'b0); add_char(7'h4F, 1'b1); run(100, 100);
    chk("count5", 0, int'(cc0), 5); chk("count5", 1, int'(cc1), 3); chk("ovf5", 1, int'(eo[1]), 1);

    // sink stalled: second char accepted then input back-pressured
    new_phase(); add_str6(ABCDEF, 1'b1);
    repeat (30) cycle(0, 100);
    for (int d = 0; d < 2; d++) begin
      chk("stall_in_ready", d, int'(ir[d]), 0);
      chk("stall_accepted", d, ptr[d], 2);
    end
    run(100, 100);
    chk_cap(0, 7, SX1, 7'b0); chk_cap(1, 7, SX1, 7'b0);

    // reset in the middle of a message
    new_phase(); add_char(7'h41, 1'b0); add_char(7'h42, 1'b0); add_char(7'h43, 1'b0);
    nd = 0;
    while ((ptr[0] < 3 || ptr[1] < 3) && nd < 200) begin cycle(100, 100); nd++; end
    chk("pre_reset_timeout", 0, int'(nd < 200), 1);
    nd = ndone[0];
    rst = 1'b1;
    #1 chk_reset_outputs();
    iv[0] = 1'b0; iv[1] = 1'b0; slen = 0;
    repeat (2) cycle(100, 0);
    rst = 1'b0;
    new_phase(); add_char(7'h41, 1'b1); run(100, 100);
    chk("post_reset_done", 0, ndone[0], nd + 1);
    chk_cap(0, 7, SX_A, 7'b0011111); chk_cap(1, 2, SX_A, 7'b0);

    // random traffic, two back-pressure mixes
    nd = ndone[0];
    new_phase(); gen_random(25); run(70, 80);
    chk("random_done_a", 0, ndone[0] - nd, 25);
    nd = ndone[1];
    new_phase(); gen_random(25); run(30, 60);
    chk("random_done_b", 1, ndone[1] - nd, 25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
